// File: rtl/rf_arb_pkg.sv
// Purpose : shared types, default widths and round-robin helper for rf_access_arbiter.
// Latency : n/a (package).
// Backpr. : n/a (package).
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int RF_AWIDTH = 4;
    localparam int RF_RWIDTH = 64;
    localparam int RF_WWIDTH = 64;

    // Requester count is capped at 8, so indices and the pointer fit in 3 bits.
    localparam int MAX_REQ = 8;
    localparam int PTR_W   = 3;

    // First set bit of valid searching from ptr+1 upward, wrapping at num.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        num);
        logic [PTR_W-1:0] win;
        logic             found;
        int unsigned      idx;
        win   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= num) begin
                idx = (32'(ptr) + k) % num;
                if (!found && valid[idx[PTR_W-1:0]]) begin
                    win   = idx[PTR_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rf_access_arbiter_rr_arbiter.sv
// Purpose : combinational round-robin winner and one-hot grant.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the parent owns the pointer and advances it only on accept.
// Ports   : i_valid (requests), i_ptr (last winner) -> o_winner, o_grant (one-hot or 0), o_any.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_winner,
    output logic [NUM_REQ-1:0] o_grant,
    output logic               o_any
);

    logic [MAX_REQ-1:0] w_valid8;

    always_comb begin
        w_valid8                = '0;
        w_valid8[NUM_REQ-1:0]   = i_valid;
    end

    assign o_any    = |i_valid;
    assign o_winner = rr_pick(w_valid8, i_ptr, NUM_REQ);
    assign o_grant  = o_any ? (NUM_REQ'(1) << o_winner) : '0;

endmodule

// File: rtl/rf_access_arbiter.sv
// Purpose : shares one openHMC register-file port between NUM_REQ requesters, one access at a time.
// Latency : accept T, RF strobe T+1, response one cycle after the cycle carrying rf_access_complete.
// Backpr. : req_ready only in IDLE; responses are single-cycle pulses with no back-pressure.
// Ports   : req_* (per-requester request side), rsp_* (response side), rf_* (controller RF port).
module rf_access_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int HMC_RF_AWIDTH = RF_AWIDTH,
    parameter int HMC_RF_RWIDTH = RF_RWIDTH,
    parameter int HMC_RF_WWIDTH = RF_WWIDTH,
    parameter int TIMEOUT_LOG   = 8
) (
    input  logic                             clk_hmc,
    input  logic                             res_hmc,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*HMC_RF_AWIDTH-1:0] req_addr,
    input  logic [NUM_REQ*HMC_RF_WWIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [HMC_RF_RWIDTH-1:0]         rsp_rdata,
    output logic                             rsp_invalid,
    output logic                             rsp_timeout,
    output logic [HMC_RF_AWIDTH-1:0]         rf_address,
    output logic                             rf_read_en,
    output logic                             rf_write_en,
    output logic [HMC_RF_WWIDTH-1:0]         rf_write_data,
    input  logic [HMC_RF_RWIDTH-1:0]         rf_read_data,
    input  logic                             rf_invalid_address,
    input  logic                             rf_access_complete
);

    state_t                     r_state;
    state_t                     w_next;
    logic [PTR_W-1:0]           r_ptr;
    logic [PTR_W-1:0]           r_id;
    logic                       r_write;
    logic [HMC_RF_AWIDTH-1:0]   r_addr;
    logic [HMC_RF_WWIDTH-1:0]   r_wdata;
    logic [TIMEOUT_LOG-1:0]     r_cnt;
    logic [HMC_RF_RWIDTH-1:0]   r_rdata;
    logic                       r_invalid;
    logic                       r_timeout;

    logic [PTR_W-1:0]           w_winner;
    logic [NUM_REQ-1:0]         w_grant;
    logic                       w_any;
    logic                       w_accept;
    logic                       w_expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_grant  (w_grant),
        .o_any    (w_any)
    );

    // The grant only ever names a valid requester, so any valid in IDLE is an accept.
    assign w_accept  = (r_state == IDLE) && w_any;
    assign w_expired = (r_cnt == {TIMEOUT_LOG{1'b1}});

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (rf_access_complete || w_expired) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_hmc) begin
        if (res_hmc) begin
            r_state   <= IDLE;
            r_ptr     <= PTR_W'(NUM_REQ - 1);
            r_id      <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_invalid <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_winner;
                        r_ptr   <= w_winner;
                        r_write <= req_write[w_winner];
                        r_addr  <= req_addr[int'(w_winner)*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
                        r_wdata <= req_wdata[int'(w_winner)*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
                    end
                end
                ISSUE: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Completion takes precedence over an expiry in the same cycle.
                    if (rf_access_complete) begin
                        r_rdata   <= rf_read_data;
                        r_invalid <= rf_invalid_address;
                        r_timeout <= 1'b0;
                    end else if (w_expired) begin
                        r_rdata   <= '0;
                        r_invalid <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == IDLE) ? w_grant : '0;
    assign rf_address    = r_addr;
    assign rf_write_data = r_wdata;
    assign rf_read_en    = (r_state == ISSUE) && !r_write;
    assign rf_write_en   = (r_state == ISSUE) &&  r_write;
    assign rsp_valid     = (r_state == RESP) ? (NUM_REQ'(1) << r_id) : '0;
    assign rsp_rdata     = r_rdata;
    assign rsp_invalid   = r_invalid;
    assign rsp_timeout   = r_timeout;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Purpose : self-checking bench for rf_access_arbiter with a response scoreboard.
// Latency : expected response cycle is derived from the RF completion delay.
// Backpr. : bench waits for req_ready with a bounded cycle budget.
module tb_rf_access_arbiter;

    localparam int NR   = 2;
    localparam int AW   = 4;
    localparam int RW   = 64;
    localparam int WW   = 64;
    localparam int TL   = 8;
    localparam int TMAX = (1 << TL) - 1;

    logic              clk_hmc = 1'b0;
    logic              res_hmc;
    logic [NR-1:0]     req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*WW-1:0]  req_wdata;
    logic [RW-1:0]     rsp_rdata, rf_read_data;
    logic              rsp_invalid, rsp_timeout;
    logic [AW-1:0]     rf_address;
    logic              rf_read_en, rf_write_en;
    logic [WW-1:0]     rf_write_data;
    logic              rf_invalid_address, rf_access_complete;

    rf_access_arbiter #(
        .NUM_REQ(NR), .HMC_RF_AWIDTH(AW), .HMC_RF_RWIDTH(RW),
        .HMC_RF_WWIDTH(WW), .TIMEOUT_LOG(TL)
    ) dut (
        .clk_hmc(clk_hmc), .res_hmc(res_hmc),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
        .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
        .rf_invalid_address(rf_invalid_address), .rf_access_complete(rf_access_complete)
    );

    always #5 clk_hmc = ~clk_hmc;

    typedef struct {
        int          id;
        logic [63:0] rdata;
        logic        inv;
        logic        to;
        int          cyc;   // response cycle counted from the strobe cycle
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  req_ready, 0);
        chk({tag, "_rspv"},   rsp_valid, 0);
        chk({tag, "_rden"},   rf_read_en, 0);
        chk({tag, "_wren"},   rf_write_en, 0);
        chk({tag, "_addr"},   rf_address, 0);
        chk({tag, "_wdata"},  rf_write_data, 0);
        chk({tag, "_rdata"},  rsp_rdata, 0);
        chk({tag, "_inv"},    rsp_invalid, 0);
        chk({tag, "_to"},     rsp_timeout, 0);
    endtask

    // Entered #1 after a rising edge. Returns #1 after the edge that starts ISSUE.
    task automatic grant(input int id, input logic [NR-1:0] others, input logic wr,
                         input logic [AW-1:0] addr, input logic [WW-1:0] wd);
        int waited = 0;
        req_write[id]            = wr;
        req_addr[id*AW +: AW]    = addr;
        req_wdata[id*WW +: WW]   = wd;
        req_valid                = others | (NR'(1) << id);
        #1;
        while (req_ready == 0 && waited < 20) begin
            @(posedge clk_hmc); #1;
            waited++;
        end
        chk("grant_onehot", req_ready, NR'(1) << id);
        @(posedge clk_hmc); #1;
        // Accepted: scramble this requester's fields to prove they were latched.
        req_valid              = others;
        req_write[id]          = ~wr;
        req_addr[id*AW +: AW]  = ~addr;
        req_wdata[id*WW +: WW] = ~wd;
        // A stray completion during ISSUE must be ignored.
        rf_access_complete = 1'b1;
        rf_read_data       = 64'hBAD0_BAD0_BAD0_BAD0;
        rf_invalid_address = 1'b1;
        chk("strobe_rd",   rf_read_en, !wr);
        chk("strobe_wr",   rf_write_en, wr);
        chk("issue_addr",  rf_address, addr);
        chk("issue_wdata", rf_write_data, wd);
        chk("issue_ready", req_ready, 0);
    endtask

    // lat = cycle after the strobe carrying rf_access_complete; 0 = never completes.
    task automatic finish(input int id, input int lat, input logic [63:0] rdat, input logic inv,
                          input logic [AW-1:0] addr, input logic [WW-1:0] wd);
        exp_t e, x;
        bit   seen = 0;
        e.id = id;
        if (lat >= 1 && lat <= TMAX + 1) begin
            e.rdata = rdat; e.inv = inv; e.to = 1'b0; e.cyc = lat + 1;
        end else begin
            e.rdata = 64'h0; e.inv = 1'b0; e.to = 1'b1; e.cyc = TMAX + 2;
        end
        sb.push_back(e);
        for (int c = 1; c <= TMAX + 10 && !seen; c++) begin
            @(posedge clk_hmc); #1;
            if (rsp_valid != 0) begin
                seen = 1;
                x = sb.pop_front();
                chk("rsp_id",    rsp_valid, NR'(1) << x.id);
                chk("rsp_rdata", rsp_rdata, x.rdata);
                chk("rsp_inv",   rsp_invalid, x.inv);
                chk("rsp_to",    rsp_timeout, x.to);
                chk("rsp_cycle", c, x.cyc);
            end else begin
                chk("no_strobe", {rf_read_en, rf_write_en}, 0);
            end
            chk("hold_addr",  rf_address, addr);
            chk("hold_wdata", rf_write_data, wd);
            rf_access_complete = (c == lat);
            rf_read_data       = (c == lat) ? rdat : {$urandom, $urandom};
            rf_invalid_address = (c == lat) ? inv : ~inv;
        end
        if (!seen) chk("rsp_seen", 0, 1);
        rf_access_complete = 1'b0;
    endtask

    initial begin
        bit any_rsp;
        res_hmc = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        rf_read_data = '0; rf_invalid_address = 1'b0; rf_access_complete = 1'b0;
        repeat (3) @(posedge clk_hmc);
        #1 res_hmc = 1'b0;
        chk_reset_outputs("reset");

        // Contention: both continuously valid, grants must alternate starting at 0.
        for (int n = 0; n < 4; n++) begin
            grant(n % 2, 2'b11, 1'b0, AW'(n + 5), 64'h0);
            finish(n % 2, 1, 64'h1000 + 64'(n), 1'b0, AW'(n + 5), 64'h0);
        end
        req_valid = '0;

        // Write from requester 1.
        grant(1, 2'b00, 1'b1, 4'h0, 64'h1234);
        finish(1, 2, 64'hFEED, 1'b0, 4'h0, 64'h1234);

        // Single read, completion 3 cycles after the strobe.
        grant(0, 2'b00, 1'b0, 4'h2, 64'h0);
        finish(0, 3, 64'hDEAD_BEEF, 1'b0, 4'h2, 64'h0);

        // Invalid address flagged by the RF.
        grant(0, 2'b00, 1'b0, 4'h7, 64'h0);
        finish(0, 2, 64'h55, 1'b1, 4'h7, 64'h0);

        // No completion at all: timeout response.
        grant(1, 2'b00, 1'b0, 4'h3, 64'h0);
        finish(1, 0, 64'h0, 1'b0, 4'h3, 64'h0);

        // Completion in the cycle the counter reads 2**TL-1: completion wins.
        grant(0, 2'b00, 1'b0, 4'h4, 64'h0);
        finish(0, TMAX + 1, 64'hA5A5, 1'b0, 4'h4, 64'h0);

        // Reset mid-WAIT on an access by requester 0 (which would hand priority to 1).
        grant(0, 2'b00, 1'b0, 4'h9, 64'hCAFE);
        rf_access_complete = 1'b0;
        repeat (5) @(posedge clk_hmc);
        #1 res_hmc = 1'b1;
        @(posedge clk_hmc);
        #1 res_hmc = 1'b0;
        chk_reset_outputs("midrst");
        any_rsp = 0;
        for (int c = 0; c < TMAX + 10; c++) begin
            @(posedge clk_hmc); #1;
            if (rsp_valid != 0) any_rsp = 1;
        end
        chk("midrst_no_rsp", any_rsp, 0);
        grant(0, 2'b11, 1'b0, 4'h1, 64'h0);
        finish(0, 1, 64'h77, 1'b0, 4'h1, 64'h0);
        req_valid = '0;

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
